// File: rtl/uart_byte_rx.sv
// ============================================================================
// Module   : uart_byte_rx
// Purpose  : 8N1 UART receiver (LSB first, idle-high line). Delivers bytes
//            over a valid/ready handshake and flags framing errors (one-cycle
//            pulse) and overruns (sticky, cleared by err_clr).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_DATA    = 3'd2;
    localparam logic [2:0] c_STOP    = 3'd3;
    localparam logic [2:0] c_WAIT_HI = 3'd4;

    // Last count of a bit period and the mid-start-bit sample point.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             rx_meta_q;
    logic             rx_s_q;
    logic [2:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       rx_data_q,   rx_data_d;
    logic             rx_valid_q,  rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic: frame FSM, shift register, handshake and error flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;

        // Consumer takes the byte; a same-edge load below overrides this.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        // Clear first so a coincident new overrun below wins.
        if (err_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            c_IDLE: begin
                cnt_d = c_CNT_ZERO;
                if (!rx_s_q) begin
                    state_d = c_START;
                end
            end
            c_START: begin
                if (cnt_q == c_CNT_MID) begin
                    cnt_d     = c_CNT_ZERO;
                    bit_idx_d = 3'd0;
                    // Line back high at mid-start means a glitch: drop silently.
                    state_d   = rx_s_q ? c_IDLE : c_DATA;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_DATA: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d     = c_CNT_ZERO;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = c_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_STOP: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d = c_CNT_ZERO;
                    if (rx_s_q) begin
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        // Leave at mid-stop so an immediately following start
                        // bit is not missed.
                        state_d = c_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = c_WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_WAIT_HI: begin
                // Hold off while the line stays low (break) to avoid restarts.
                cnt_d = c_CNT_ZERO;
                if (rx_s_q) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = c_CNT_ZERO;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_IDLE;
            cnt_q       <= c_CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// ============================================================================
// Module   : tb_uart_byte_rx
// Purpose  : Self-checking bench for uart_byte_rx (CLKS_PER_BIT = 8) using an
//            expected-byte queue filled by the serial driver and drained by a
//            handshake monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_byte_rx;

    localparam int c_CPB = 8;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       busy;

    int         n_chk;
    int         n_err;
    int         fe_cnt;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_byte_rx #(.CLKS_PER_BIT(c_CPB)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Handshake monitor: each negedge with valid&&ready is one consumed byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("rx_data", {24'h0, rx_data}, {24'h0, exp_b});
                end
            end
        end
    end

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (c_CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
    endtask

    // Wait (bounded) until all expected bytes have been consumed.
    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        fe_cnt   = 0;
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_rx_data",   {24'h0, rx_data}, 32'h0);
        chk("rst_rx_valid",  {31'h0, rx_valid}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        chk("rst_overrun",   {31'h0, overrun}, 32'h0);
        chk("rst_busy",      {31'h0, busy}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte with consumer always ready.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("drain_A5");
        chk("A5_frame_err", fe_cnt, 0);
        chk("A5_overrun", {31'h0, overrun}, 32'h0);
        repeat (10) @(negedge clk);

        // Back-to-back frames, no idle gap.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("drain_00_FF");
        repeat (10) @(negedge clk);
        chk("b2b_busy_idle", {31'h0, busy}, 32'h0);

        // Short low glitch must be ignored.
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_valid", {31'h0, rx_valid}, 32'h0);
        chk("glitch_fe",    fe_cnt, 0);
        chk("glitch_busy",  {31'h0, busy}, 32'h0);

        // Framing error followed by a break, then a good byte.
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("break_busy",  {31'h0, busy}, 32'h1);
        chk("fe_once",     fe_cnt, 1);
        chk("fe_no_valid", {31'h0, rx_valid}, 32'h0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("fe_idle", {31'h0, busy}, 32'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("drain_81");
        chk("fe_total", fe_cnt, 1);
        repeat (10) @(negedge clk);

        // Overrun: consumer stalled, second byte dropped.
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        chk("ovr_data",    {24'h0, rx_data}, 32'h11);
        chk("ovr_valid",   {31'h0, rx_valid}, 32'h1);
        chk("ovr_flag",    {31'h0, overrun}, 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", {31'h0, overrun}, 32'h0);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_consumed", {31'h0, rx_valid}, 32'h0);
        wait_drain("drain_11");

        // Reset in the middle of 0x5A (during data bit 4), then 0xC3.
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'(8'h5A >> i));
        rx = 1'b1;
        repeat (c_CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy",  {31'h0, busy}, 32'h0);
        chk("mid_rst_valid", {31'h0, rx_valid}, 32'h0);
        chk("mid_rst_data",  {24'h0, rx_data}, 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        wait_drain("drain_C3");
        repeat (20) @(negedge clk);
        chk("final_valid", {31'h0, rx_valid}, 32'h0);
        chk("final_fe",    fe_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
